// File: rtl/student_fir_out_stage.sv
// FIR output stage: arithmetic shift, saturate/wrap to OUT_WIDTH, and a small show-ahead FIFO
// toward the IIS handler, with clip/peak statistics and sticky over/underflow flags.
module student_fir_out_stage #(
  parameter int unsigned IN_WIDTH   = 27,
  parameter int unsigned OUT_WIDTH  = 24,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        valid_strobe_in,
  input  logic signed [IN_WIDTH-1:0]  y_in,
  input  logic        [4:0]           shift_i,
  input  logic                        sat_en_i,
  input  logic                        clr_i,
  input  logic                        sample_ready_i,
  output logic        [OUT_WIDTH-1:0] sample_o,
  output logic                        sample_valid_o,
  output logic        [15:0]          clip_cnt_o,
  output logic        [OUT_WIDTH-2:0] peak_o,
  output logic                        overflow_o,
  output logic                        underflow_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned HI_W  = IN_WIDTH - OUT_WIDTH + 1;

  logic signed [IN_WIDTH-1:0]  shifted_c;
  logic signed [IN_WIDTH-1:0]  s1_data;
  logic                        s1_valid;
  logic        [HI_W-1:0]      s1_hi;
  logic                        oor_c;
  logic        [OUT_WIDTH-1:0] wdata_c;
  logic        [OUT_WIDTH-1:0] neg_c;
  logic        [OUT_WIDTH-2:0] mag_c;

  logic        [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic        [PTR_W-1:0]     rd_ptr, wr_ptr, rd_ptr_n;
  logic        [CNT_W-1:0]     count, count_n;
  logic        [OUT_WIDTH-1:0] head_n;
  logic                        full_c, empty_c, push_c, pop_c;

  // Shifts of IN_WIDTH or more leave only sign bits
  always_comb begin
    if (32'(shift_i) >= IN_WIDTH) shifted_c = {IN_WIDTH{y_in[IN_WIDTH-1]}};
    else                          shifted_c = y_in >>> shift_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= valid_strobe_in;
      if (valid_strobe_in) s1_data <= shifted_c;
    end
  end

  // In range iff every bit from the MSB down to the output sign bit agrees
  assign s1_hi = s1_data[IN_WIDTH-1:OUT_WIDTH-1];
  assign oor_c = !((&s1_hi) || !(|s1_hi));

  always_comb begin
    if (oor_c && sat_en_i)
      wdata_c = s1_data[IN_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                    : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else
      wdata_c = s1_data[OUT_WIDTH-1:0];
  end

  // Magnitude of the written sample; the most negative code clamps to all ones
  assign neg_c = ~wdata_c + OUT_WIDTH'(1);
  always_comb begin
    if (!wdata_c[OUT_WIDTH-1])             mag_c = wdata_c[OUT_WIDTH-2:0];
    else if (wdata_c[OUT_WIDTH-2:0] == '0) mag_c = '1;
    else                                   mag_c = neg_c[OUT_WIDTH-2:0];
  end

  assign full_c  = (count == CNT_W'(FIFO_DEPTH));
  assign empty_c = (count == '0);
  assign pop_c   = sample_ready_i && !empty_c;
  assign push_c  = s1_valid && (!full_c || pop_c);

  // Next-state of occupancy and head so sample_o/sample_valid_o can be registered
  always_comb begin
    count_n  = count;
    rd_ptr_n = rd_ptr;
    head_n   = '0;
    if (push_c && !pop_c) count_n = count + CNT_W'(1);
    if (pop_c && !push_c) count_n = count - CNT_W'(1);
    if (pop_c)            rd_ptr_n = rd_ptr + PTR_W'(1);
    if (count_n != '0) begin
      if (push_c && (wr_ptr == rd_ptr_n)) head_n = wdata_c;
      else                                head_n = mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_c) mem[wr_ptr] <= wdata_c;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      clip_cnt_o     <= '0;
      peak_o         <= '0;
      overflow_o     <= 1'b0;
      underflow_o    <= 1'b0;
    end else begin
      rd_ptr         <= rd_ptr_n;
      count          <= count_n;
      sample_o       <= head_n;
      sample_valid_o <= (count_n != '0);
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (clr_i) begin
        clip_cnt_o  <= '0;
        peak_o      <= '0;
        overflow_o  <= 1'b0;
        underflow_o <= 1'b0;
      end else begin
        if (s1_valid && oor_c && (clip_cnt_o != 16'hFFFF)) clip_cnt_o <= clip_cnt_o + 16'd1;
        if (push_c && (mag_c > peak_o))                     peak_o     <= mag_c;
        if (s1_valid && full_c && !pop_c)                   overflow_o <= 1'b1;
        if (sample_ready_i && empty_c)                      underflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_student_fir_out_stage.sv
// Directed bench for student_fir_out_stage: expected samples are queued by the stimulus
// and a negedge monitor checks them at each handshake; statistics are checked inline.
module tb_student_fir_out_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_strobe_in = 1'b0;
  logic [26:0] y_in = '0;
  logic [4:0]  shift_i = '0;
  logic        sat_en_i = 1'b0;
  logic        clr_i = 1'b0;
  logic        sample_ready_i = 1'b0;
  logic [23:0] sample_o;
  logic        sample_valid_o;
  logic [15:0] clip_cnt_o;
  logic [22:0] peak_o;
  logic        overflow_o;
  logic        underflow_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [23:0] exp_q[$];

  student_fir_out_stage dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .valid_strobe_in(valid_strobe_in),
    .y_in           (y_in),
    .shift_i        (shift_i),
    .sat_en_i       (sat_en_i),
    .clr_i          (clr_i),
    .sample_ready_i (sample_ready_i),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .clip_cnt_o     (clip_cnt_o),
    .peak_o         (peak_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobe, then one idle cycle holding sat_en_i so stage 2 sees the same setting
  task automatic send(input logic [26:0] y, input logic [4:0] sh, input logic sat);
    y_in = y; shift_i = sh; sat_en_i = sat; valid_strobe_in = 1'b1;
    tick();
    valid_strobe_in = 1'b0;
    tick();
  endtask

  task automatic drain(input int n);
    sample_ready_i = 1'b1;
    for (int i = 0; i < n; i++) tick();
    sample_ready_i = 1'b0;
  endtask

  task automatic check_stats(input string tag, input logic [15:0] clip, input logic [22:0] pk,
                             input logic ov, input logic un);
    check({tag, ".clip_cnt"}, 32'(clip_cnt_o), 32'(clip));
    check({tag, ".peak"}, 32'(peak_o), 32'(pk));
    check({tag, ".overflow"}, 32'(overflow_o), 32'(ov));
    check({tag, ".underflow"}, 32'(underflow_o), 32'(un));
  endtask

  // Monitor: a handshake completes on the next posedge when valid and ready are both high
  always @(negedge clk) begin
    if (!rst && sample_valid_o && sample_ready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_sample: got 0x%0h, expected none", sample_o);
      end else begin
        check("sample", 32'(sample_o), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    // Reset state
    tick(); tick();
    check("rst.sample", 32'(sample_o), 32'h0);
    check("rst.valid", 32'(sample_valid_o), 32'h0);
    check_stats("rst", 16'h0, 23'h0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // Basic sample and 2-cycle latency
    y_in = 27'h0001234; shift_i = 5'd0; sat_en_i = 1'b1; valid_strobe_in = 1'b1;
    tick();
    valid_strobe_in = 1'b0;
    check("lat.valid_n", 32'(sample_valid_o), 32'h0);
    tick();
    check("lat.valid_n1", 32'(sample_valid_o), 32'h1);
    exp_q.push_back(24'h001234);
    check_stats("basic", 16'd0, 23'h001234, 1'b0, 1'b0);
    drain(1);
    check("basic.empty", 32'(sample_valid_o), 32'h0);

    // Positive overrange: saturate, then wrap
    send(27'h1000000, 5'd0, 1'b1); exp_q.push_back(24'h7FFFFF);
    send(27'h1000000, 5'd0, 1'b0); exp_q.push_back(24'h000000);
    check("pos_oor.clip", 32'(clip_cnt_o), 32'd2);
    drain(2);

    // -2^26 >>> 3 is exactly the most negative output code
    send(27'h4000000, 5'd3, 1'b1); exp_q.push_back(24'h800000);
    check("minval.clip", 32'(clip_cnt_o), 32'd2);
    check("minval.peak", 32'(peak_o), 32'h7FFFFF);
    drain(1);

    // Shifts beyond the input width collapse to sign bits
    send(27'h7FFFFFB, 5'd31, 1'b1); exp_q.push_back(24'hFFFFFF);
    send(27'h0FFFFFF, 5'd30, 1'b1); exp_q.push_back(24'h000000);
    drain(2);

    // Negative overrange (-2^24-1): saturate, then wrap
    send(27'h6FFFFFF, 5'd0, 1'b1); exp_q.push_back(24'h800000);
    send(27'h6FFFFFF, 5'd0, 1'b0); exp_q.push_back(24'hFFFFFF);
    check("neg_oor.clip", 32'(clip_cnt_o), 32'd4);
    drain(2);

    clr_i = 1'b1; tick(); clr_i = 1'b0;
    check_stats("clr1", 16'd0, 23'h0, 1'b0, 1'b0);

    // Back-to-back burst into a 4-deep FIFO; the 5th sample is dropped
    sat_en_i = 1'b1; shift_i = 5'd0;
    for (int i = 1; i <= 5; i++) begin
      y_in = 27'(i * 16); valid_strobe_in = 1'b1;
      if (i <= 4) exp_q.push_back(24'(i * 16));
      tick();
    end
    valid_strobe_in = 1'b0;
    tick(); tick();
    check("burst.valid", 32'(sample_valid_o), 32'h1);
    check_stats("burst", 16'd0, 23'h40, 1'b1, 1'b0);

    clr_i = 1'b1; tick(); clr_i = 1'b0;
    check_stats("clr2", 16'd0, 23'h0, 1'b0, 1'b0);
    check("clr2.head", 32'(sample_o), 32'h10);

    // Push and pop on the same edge while full
    y_in = 27'h60; valid_strobe_in = 1'b1;
    tick();
    valid_strobe_in = 1'b0; sample_ready_i = 1'b1;
    exp_q.push_back(24'h60);
    tick();
    sample_ready_i = 1'b0;
    check("pushpop.overflow", 32'(overflow_o), 32'h0);
    check("pushpop.peak", 32'(peak_o), 32'h60);
    drain(4);
    check("drain4.valid", 32'(sample_valid_o), 32'h0);
    check("drain4.underflow", 32'(underflow_o), 32'h0);
    sample_ready_i = 1'b1; tick(); sample_ready_i = 1'b0;
    check("underflow", 32'(underflow_o), 32'h1);

    // Clear wins over a same-cycle clip/peak event
    y_in = 27'h1000000; sat_en_i = 1'b1; valid_strobe_in = 1'b1;
    tick();
    valid_strobe_in = 1'b0; clr_i = 1'b1;
    exp_q.push_back(24'h7FFFFF);
    tick();
    clr_i = 1'b0;
    check_stats("clrwin", 16'd0, 23'h0, 1'b0, 1'b0);
    drain(1);

    // Reset one cycle after a strobe discards the in-flight sample
    y_in = 27'h777; valid_strobe_in = 1'b1;
    tick();
    valid_strobe_in = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    check("midrst.valid", 32'(sample_valid_o), 32'h0);
    check("midrst.sample", 32'(sample_o), 32'h0);
    check_stats("midrst", 16'd0, 23'h0, 1'b0, 1'b0);
    y_in = 27'h42; valid_strobe_in = 1'b1;
    tick();
    valid_strobe_in = 1'b0;
    check("postrst.valid_n", 32'(sample_valid_o), 32'h0);
    tick();
    check("postrst.valid_n1", 32'(sample_valid_o), 32'h1);
    exp_q.push_back(24'h42);
    drain(1);
    tick();

    check("scoreboard.left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
